// File: rtl/mix_columns_sequencer_pkg.sv
// mix_columns_sequencer_pkg: shared widths, coefficient rows and FSM encoding for the MixColumns engine
package mix_columns_sequencer_pkg;
  localparam int STATE_W = 128;
  localparam int BYTE_W = 8;
  localparam logic [15:0] ENC_COEF = 16'h2311;
  localparam logic [15:0] DEC_COEF = 16'hebd9;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [3:0] coef_sel(input logic inverse, input logic [1:0] j);
    logic [15:0] r;
    logic [3:0] pos;
    r = inverse ? DEC_COEF : ENC_COEF;
    pos = 4'd15 - {j, 2'b00};
    return r[pos -: 4];
  endfunction
endpackage

// File: rtl/mix_columns_sequencer_gf_mul.sv
// gf_mul_byte: combinational GF(2^8) multiply of a byte by a 4-bit coefficient, reduced by 0x11B
module gf_mul_byte (
  input  logic [7:0] a,
  input  logic [3:0] coef,
  output logic [7:0] p
);
  logic [10:0] raw;
  logic [10:0] red;
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) raw = coef[i] ? raw ^ ({3'b000, a} << i) : raw;
    red = raw;
    for (int i = 10; i >= 8; i--) red = red[i] ? red ^ (11'h11b << (i - 8)) : red;
    p = red[7:0];
  end
endmodule

// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: sequential MixColumns/InvMixColumns, one GF(2^8) product per clock
module mix_columns_sequencer
  import mix_columns_sequencer_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);
  state_t state;
  logic [5:0] cnt;
  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] acc;
  logic [STATE_W-1:0] acc_nxt;
  logic [1:0] col, row, k;
  logic [6:0] src_pos, dst_pos;
  logic [BYTE_W-1:0] a, p;
  logic [3:0] coef;
  assign {col, row, k} = cnt;
  assign src_pos = 7'd127 - {col, k, 3'b000};
  assign dst_pos = 7'd127 - {col, row, 3'b000};
  assign a = s[src_pos -: 8];
  assign coef = coef_sel(INVERSE, k - row);
  gf_mul_byte u_mul (.a(a), .coef(coef), .p(p));
  always_comb begin
    acc_nxt = acc;
    acc_nxt[dst_pos -: 8] = acc[dst_pos -: 8] ^ p;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      cnt <= '0;
      acc <= '0;
      s <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s <= in_data;
          acc <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            out_data <= acc_nxt;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
